// File: rtl/lfsr_im_sched.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_im_sched
//  Description : Shares the HDC item-memory LFSR between the channel-ID path
//                (requester 0) and the level-ID path (requester 1). Item k is
//                the LFSR state after k enables from SEED. The scheduler
//                tracks the LFSR position and either steps forward or
//                restarts from SEED and steps to reach the requested item.
//  Revision    : 1.0  initial release
// ============================================================================
module lfsr_im_sched #(
    parameter int NUM_ITEMS = 64,
    parameter int IDX_W     = $clog2(NUM_ITEMS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [IDX_W-1:0] idx0,
    input  logic [IDX_W-1:0] idx1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic             lfsr_en,
    output logic             lfsr_nrst,
    output logic [IDX_W-1:0] pos
);

    // Highest legal item index; larger requests are clamped to it.
    localparam logic [IDX_W-1:0] C_MAX_IDX = IDX_W'(NUM_ITEMS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RESTART = 2'd1,
        S_STEP    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] pos_q,   pos_d;
    logic [IDX_W-1:0] tgt_q,   tgt_d;
    logic             owner_q, owner_d;
    logic             last_q,  last_d;

    // Registered Moore outputs, loaded from the next-state values so they
    // line up with the state they describe.
    logic [1:0]       gnt_q;
    logic [1:0]       done_q;
    logic             busy_q;
    logic             en_q;
    logic             nrst_q;

    // Arbitration result for the current IDLE cycle.
    logic             w_any;
    logic             w_win;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_tgt;
    logic [IDX_W-1:0] w_pos_inc;

    // Round-robin pick: on a tie the requester that was not served last wins;
    // a lone request wins regardless of history. Index is clamped on latch.
    always_comb begin
        w_any = |req;
        w_win = 1'b0;
        if (req == 2'b11) begin
            w_win = ~last_q;
        end else begin
            w_win = req[1];
        end
        w_idx = w_win ? idx1 : idx0;
        w_tgt = (w_idx > C_MAX_IDX) ? C_MAX_IDX : w_idx;
    end

    assign w_pos_inc = pos_q + IDX_W'(1);

    // Next-state logic: walk the LFSR forward, or restart it from SEED when
    // the target lies behind the current position.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        tgt_d   = tgt_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (w_any) begin
                    tgt_d   = w_tgt;
                    owner_d = w_win;
                    last_d  = w_win;
                    if (w_tgt == pos_q) begin
                        state_d = S_DONE;
                    end else if (w_tgt > pos_q) begin
                        state_d = S_STEP;
                    end else begin
                        state_d = S_RESTART;
                    end
                end
            end
            S_RESTART: begin
                // LFSR is held at SEED for this cycle, so position returns to 0.
                pos_d   = '0;
                state_d = (tgt_q != '0) ? S_STEP : S_DONE;
            end
            S_STEP: begin
                // One enable per cycle; leave on the edge that reaches the target.
                pos_d = w_pos_inc;
                if (w_pos_inc == tgt_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, bookkeeping and registered output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pos_q   <= '0;
            tgt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            nrst_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            tgt_q   <= tgt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt_q   <= (state_d != S_IDLE) ? {owner_d, ~owner_d} : 2'b00;
            done_q  <= (state_d == S_DONE) ? {owner_d, ~owner_d} : 2'b00;
            busy_q  <= (state_d != S_IDLE);
            en_q    <= (state_d == S_STEP);
            nrst_q  <= (state_d != S_RESTART);
        end
    end

    // The LFSR controls are also gated by reset directly, so the LFSR is held
    // at SEED while reset is asserted, keeping it consistent with pos == 0.
    assign lfsr_en   = en_q & ~rst;
    assign lfsr_nrst = nrst_q & ~rst;
    assign gnt       = gnt_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign pos       = pos_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_im_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_im_sched
//  Description : Self-checking bench for lfsr_im_sched with a behavioural LFSR
//                attached to the scheduler's en/nrst outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lfsr_im_sched;

    localparam int          NUM_ITEMS = 50;
    localparam int          IDX_W     = 6;
    localparam logic [15:0] SEED      = 16'hACE1;

    logic             clk;
    logic             rst;
    logic [1:0]       req;
    logic [IDX_W-1:0] idx0;
    logic [IDX_W-1:0] idx1;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             busy;
    logic             lfsr_en;
    logic             lfsr_nrst;
    logic [IDX_W-1:0] pos;

    int n_checks;
    int n_errors;

    lfsr_im_sched #(
        .NUM_ITEMS (NUM_ITEMS),
        .IDX_W     (IDX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .idx0      (idx0),
        .idx1      (idx1),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .lfsr_en   (lfsr_en),
        .lfsr_nrst (lfsr_nrst),
        .pos       (pos)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [15:0] item(input int k);
        logic [15:0] s;
        s = SEED;
        for (int i = 0; i < k; i++) s = lfsr_next(s);
        return s;
    endfunction

    // Behavioural item-memory LFSR driven by the scheduler.
    logic [15:0] ties_q;
    always @(posedge clk or negedge lfsr_nrst) begin
        if (!lfsr_nrst) ties_q <= SEED;
        else if (lfsr_en) ties_q <= lfsr_next(ties_q);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one request at a negedge in IDLE and follow it to its done pulse.
    task automatic run_txn(input string tag, input logic [1:0] r,
                           input logic [IDX_W-1:0] i0, input logic [IDX_W-1:0] i1,
                           input logic [1:0] oh, input int ep, input int el,
                           input int een, input int ers, input logic [1:0] keep);
        int cyc;
        int en_c;
        int rs_c;
        bit seen;
        req  = r;
        idx0 = i0;
        idx1 = i1;
        cyc  = 0;
        en_c = 0;
        rs_c = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (lfsr_en) en_c++;
            if (!lfsr_nrst) rs_c++;
            if (done != 2'b00) seen = 1'b1;
        end
        chk({tag, ".done"},    int'(done), int'(oh));
        chk({tag, ".gnt"},     int'(gnt),  int'(oh));
        chk({tag, ".busy"},    int'(busy), 1);
        chk({tag, ".pos"},     int'(pos),  ep);
        chk({tag, ".latency"}, cyc,        el);
        chk({tag, ".en_cyc"},  en_c,       een);
        chk({tag, ".rst_cyc"}, rs_c,       ers);
        chk({tag, ".ties"},    int'(ties_q), int'(item(ep)));
        req = keep;
        @(negedge clk);
        chk({tag, ".done_pulse"}, int'(done), 0);
        chk({tag, ".idle"},       int'(busy), 0);
    endtask

    typedef struct {
        logic [1:0]       req;
        logic [IDX_W-1:0] i0;
        logic [IDX_W-1:0] i1;
        logic [1:0]       oh;
        int               pos;
        int               lat;
        int               en;
        int               rs;
    } vec_t;

    vec_t tbl[12];

    task automatic do_reset();
        req  = 2'b00;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        bit quiet;
        n_checks = 0;
        n_errors = 0;
        req  = 2'b00;
        idx0 = '0;
        idx1 = '0;
        rst  = 1'b1;

        //          req    i0  i1  oh     pos lat en rs
        tbl[0]  = '{2'b01,  0,  0, 2'b01,  0,  1,  0, 0};
        tbl[1]  = '{2'b01,  5,  0, 2'b01,  5,  6,  5, 0};
        tbl[2]  = '{2'b10,  0,  7, 2'b10,  7,  3,  2, 0};
        tbl[3]  = '{2'b10,  0,  3, 2'b10,  3,  5,  3, 1};
        tbl[4]  = '{2'b01,  3,  0, 2'b01,  3,  1,  0, 0};
        tbl[5]  = '{2'b01,  0,  0, 2'b01,  0,  2,  0, 1};
        tbl[6]  = '{2'b01, 53,  0, 2'b01, 49, 50, 49, 0};
        tbl[7]  = '{2'b10,  0, 63, 2'b10, 49,  1,  0, 0};
        tbl[8]  = '{2'b10,  0, 48, 2'b10, 48, 50, 48, 1};
        tbl[9]  = '{2'b11, 10, 20, 2'b01, 10, 12, 10, 1};
        tbl[10] = '{2'b11, 10, 20, 2'b10, 20, 11, 10, 0};
        tbl[11] = '{2'b11, 25,  2, 2'b01, 25,  6,  5, 0};

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        chk("rst.busy",  int'(busy),      0);
        chk("rst.gnt",   int'(gnt),       0);
        chk("rst.done",  int'(done),      0);
        chk("rst.en",    int'(lfsr_en),   0);
        chk("rst.nrst",  int'(lfsr_nrst), 0);
        chk("rst.pos",   int'(pos),       0);
        chk("rst.ties",  int'(ties_q),    int'(SEED));
        rst = 1'b0;
        #1;
        chk("rel.nrst",  int'(lfsr_nrst), 1);

        for (int i = 0; i < 12; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i].req, tbl[i].i0, tbl[i].i1,
                    tbl[i].oh, tbl[i].pos, tbl[i].lat, tbl[i].en, tbl[i].rs, 2'b00);
        end

        // Tie held from reset: requester 0 first, requester 1 kept and served next.
        do_reset();
        run_txn("tie_a", 2'b11, 6'd4, 6'd6, 2'b01, 4, 5, 4, 0, 2'b10);
        run_txn("tie_b", 2'b10, 6'd4, 6'd6, 2'b10, 6, 3, 2, 0, 2'b00);

        // Reset while stepping towards index 10.
        do_reset();
        req  = 2'b01;
        idx0 = 6'd10;
        guard = 0;
        while (pos != 6'd3 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("mid.reach_pos3", int'(pos), 3);
        chk("mid.busy_before", int'(busy), 1);
        req = 2'b00;
        rst = 1'b1;
        #1;
        chk("mid.busy", int'(busy),      0);
        chk("mid.en",   int'(lfsr_en),   0);
        chk("mid.nrst", int'(lfsr_nrst), 0);
        chk("mid.pos",  int'(pos),       0);
        chk("mid.gnt",  int'(gnt),       0);
        chk("mid.done", int'(done),      0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done != 2'b00 || busy) quiet = 1'b0;
        end
        chk("mid.no_done", int'(quiet), 1);
        run_txn("mid_rerun", 2'b01, 6'd2, 6'd0, 2'b01, 2, 3, 2, 0, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
